ahb_line_master: RTL

Bus initiator that sits between the cache controller and the AHB-lite memory subsystem and drives HREQUEST/HADDR/HWRITE/HWDATA. It turns one cache-side request into a sequence of single-word bus beats: a line fill (read), a line writeback (write), or a single uncached word. It collects read data and returns the result to the cache in one response cycle. It is the initiator counterpart of the memory-side bus wrapper, which answers each beat with HRDATA/HREADY.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/ahb_line_master_if.sv | 38 +++
 rtl/ahb_line_master.sv | 111 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB line master.
// Word width and line-offset helper derived from words per line.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } ahb_mst_state_t;

  localparam int WORD_W = 32;

  function automatic int line_off_w(input int lw);
    return $clog2(lw) + 2;
  endfunction

endpackage

// File: rtl/ahb_line_master_if.sv
// Cache-side request/response and AHB-lite beat signals.
// master: the line master's view; slave: cache plus memory view.
interface ahb_line_master_if #(
  parameter int LINE_WORDS = 4
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic                     req_single;
  logic [31:0]              req_addr;
  logic [32*LINE_WORDS-1:0] req_wdata;
  logic                     resp_valid;
  logic [32*LINE_WORDS-1:0] resp_rdata;
  logic                     HREQUEST;
  logic [31:0]              HADDR;
  logic                     HWRITE;
  logic [31:0]              HWDATA;
  logic [31:0]              HRDATA;
  logic                     HREADY;

  modport master (
    input  req_valid, req_write, req_single,
    input  req_addr, req_wdata,
    input  HRDATA, HREADY,
    output req_ready, resp_valid, resp_rdata,
    output HREQUEST, HADDR, HWRITE, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_single,
    output req_addr, req_wdata,
    output HRDATA, HREADY,
    input  req_ready, resp_valid, resp_rdata,
    input  HREQUEST, HADDR, HWRITE, HWDATA
  );

endinterface

// File: rtl/ahb_line_master.sv
// Turns one cache request into ascending single-word AHB beats.
// Collects read data and returns it in a one-cycle response.
module ahb_line_master
  import ahb_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_line_master_if.master bus
);

  localparam int OFFW   = $clog2(LINE_WORDS);
  localparam int LOFF   = line_off_w(LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_XFER = XFER;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [OFFW-1:0] LAST = OFFW'(LINE_WORDS - 1);

  logic [1:0]        state;
  logic              wr_q;
  logic              single_q;
  logic [31-LOFF:0]  base_q;
  logic [OFFW-1:0]   sidx_q;
  logic [OFFW-1:0]   cnt;
  logic [LINE_W-1:0] wdata_q;

  logic [OFFW-1:0]   idx;
  logic [OFFW-1:0]   nidx;
  logic [OFFW-1:0]   fidx;
  logic              last;
  logic              unused_ok;

  always_comb begin
    idx  = single_q ? sidx_q : cnt;
    nidx = cnt + OFFW'(1);
    last = single_q || (cnt == LAST);
    fidx = bus.req_single ? bus.req_addr[LOFF-1:2] : '0;
  end

  // byte offset within a word never reaches the bus
  assign unused_ok = &{1'b0, bus.req_addr[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= S_IDLE;
      wr_q            <= 1'b0;
      single_q        <= 1'b0;
      base_q          <= '0;
      sidx_q          <= '0;
      cnt             <= '0;
      wdata_q         <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.HREQUEST    <= 1'b0;
      bus.HADDR       <= '0;
      bus.HWRITE      <= 1'b0;
      bus.HWDATA      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            state          <= S_XFER;
            wr_q           <= bus.req_write;
            single_q       <= bus.req_single;
            base_q         <= bus.req_addr[31:LOFF];
            sidx_q         <= bus.req_addr[LOFF-1:2];
            cnt            <= '0;
            wdata_q        <= bus.req_wdata;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b0;
            bus.HREQUEST   <= 1'b1;
            bus.HWRITE     <= bus.req_write;
            bus.HADDR      <= {bus.req_addr[31:LOFF], fidx, 2'b00};
            bus.HWDATA     <= bus.req_wdata[{fidx, 5'd0} +: WORD_W];
          end
        end
        S_XFER: begin
          if (bus.HREADY) begin
            if (!wr_q) begin
              bus.resp_rdata[{idx, 5'd0} +: WORD_W] <= bus.HRDATA;
            end
            cnt <= nidx;
            if (last) begin
              state          <= S_DONE;
              bus.HREQUEST   <= 1'b0;
              bus.HWRITE     <= 1'b0;
              bus.HADDR      <= '0;
              bus.HWDATA     <= '0;
              bus.resp_valid <= 1'b1;
            end else begin
              bus.HADDR  <= {base_q, nidx, 2'b00};
              bus.HWDATA <= wdata_q[{nidx, 5'd0} +: WORD_W];
            end
          end
        end
        S_DONE: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
